// File: rtl/prog_lut.sv
// Programmable key->value lookup table with per-entry valid bits, registered
// reads (read-before-write) and a clear sweep after reset or on init.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_CLEAR | sweeping entries to DEFAULT_VAL, reads/writes are dropped
//  ST_IDLE  | table usable: writes update entries, reads return hit/miss
module prog_lut #(
    parameter int unsigned       KEY_W       = 8,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       DEPTH       = 32,
    parameter logic [DATA_W-1:0] DEFAULT_VAL = '0,
    localparam int unsigned      CNT_W       = $clog2(DEPTH + 1),
    localparam int unsigned      PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              init_i,
    output logic              busy_o,
    input  logic              wr_en_i,
    input  logic [KEY_W-1:0]  wr_key_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_err_o,
    input  logic              rd_en_i,
    input  logic [KEY_W-1:0]  rd_key_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_hit_o,
    output logic [CNT_W-1:0]  count_o
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_hit_q, rd_hit_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              wr_err_q, wr_err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [PTR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              wr_in_range, rd_in_range;
    logic [PTR_W-1:0]  wr_idx, rd_idx;
    logic              accept;
    logic              rd_hit_now;

    assign wr_in_range = (32'(wr_key_i) < DEPTH);
    assign rd_in_range = (32'(rd_key_i) < DEPTH);
    assign wr_idx      = wr_in_range ? wr_key_i[PTR_W-1:0] : '0;
    assign rd_idx      = rd_in_range ? rd_key_i[PTR_W-1:0] : '0;
    // init wins over any access presented on the same edge
    assign accept      = (state_q == ST_IDLE) && !init_i;
    assign rd_hit_now  = rd_in_range && valid_q[rd_idx];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        valid_d    = valid_q;
        count_d    = count_q;
        rd_valid_d = 1'b0;
        rd_hit_d   = rd_hit_q;
        rd_data_d  = rd_data_q;
        wr_err_d   = wr_en_i && (!accept || !wr_in_range);
        mem_we     = 1'b0;
        mem_waddr  = ptr_q;
        mem_wdata  = DEFAULT_VAL;

        case (state_q)
            ST_CLEAR: begin
                mem_we          = 1'b1;
                valid_d[ptr_q]  = 1'b0;
                if (init_i) begin
                    ptr_d   = '0;
                    valid_d = '0;
                    count_d = '0;
                end else if (ptr_q == PTR_W'(DEPTH - 1)) begin
                    ptr_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            ST_IDLE: begin
                if (init_i) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                    valid_d = '0;
                    count_d = '0;
                end else begin
                    if (rd_en_i) begin
                        rd_valid_d = 1'b1;
                        rd_hit_d   = rd_hit_now;
                        rd_data_d  = rd_hit_now ? mem_q[rd_idx] : DEFAULT_VAL;
                    end
                    if (wr_en_i && wr_in_range) begin
                        mem_we          = 1'b1;
                        mem_waddr       = wr_idx;
                        mem_wdata       = wr_data_i;
                        valid_d[wr_idx] = 1'b1;
                        if (!valid_q[wr_idx]) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= '0;
            valid_q    <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_data_q  <= DEFAULT_VAL;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
            rd_data_q  <= rd_data_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // Storage has no reset: stale data is masked by the valid bits.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign busy_o     = (state_q == ST_CLEAR);
    assign wr_err_o   = wr_err_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign rd_hit_o   = rd_hit_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_prog_lut.sv
// Randomized self-checking bench for prog_lut against an array-based model
// of the table contents, sweep timing and registered read/write responses.
module tb_prog_lut;

    localparam int KEY_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH = 32;
    localparam logic [DATA_W-1:0] DEFV = 8'h00;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              init;
    logic              busy;
    logic              wr_en;
    logic [KEY_W-1:0]  wr_key;
    logic [DATA_W-1:0] wr_data;
    logic              wr_err;
    logic              rd_en;
    logic [KEY_W-1:0]  rd_key;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_hit;
    logic [CNT_W-1:0]  count;

    prog_lut #(.KEY_W(KEY_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .DEFAULT_VAL(DEFV)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .init_i(init), .busy_o(busy),
        .wr_en_i(wr_en), .wr_key_i(wr_key), .wr_data_i(wr_data), .wr_err_o(wr_err),
        .rd_en_i(rd_en), .rd_key_i(rd_key), .rd_valid_o(rd_valid),
        .rd_data_o(rd_data), .rd_hit_o(rd_hit), .count_o(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    int          busy_left;
    bit          m_ok  [DEPTH];
    logic [7:0]  m_val [DEPTH];
    logic        e_rv, e_hit, e_werr;
    logic [7:0]  e_rd;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += m_ok[i] ? 1 : 0;
        return c;
    endfunction

    task automatic model_reset();
        busy_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_ok[i] = 1'b0;
        e_rv = 1'b0; e_hit = 1'b0; e_werr = 1'b0; e_rd = DEFV;
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".busy"},   32'(busy),     32'(busy_left > 0));
        check_val({tag, ".count"},  32'(count),    32'(model_count()));
        check_val({tag, ".rd_vld"}, 32'(rd_valid), 32'(e_rv));
        check_val({tag, ".rd_hit"}, 32'(rd_hit),   32'(e_hit));
        check_val({tag, ".rd_dat"}, 32'(rd_data),  32'(e_rd));
        check_val({tag, ".wr_err"}, 32'(wr_err),   32'(e_werr));
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic step(input string tag, input logic i_init,
                        input logic i_wr, input int wk, input logic [7:0] wd,
                        input logic i_rd, input int rk);
        bit dropped;
        init = i_init; wr_en = i_wr; wr_key = 8'(wk); wr_data = wd;
        rd_en = i_rd; rd_key = 8'(rk);
        @(posedge clk);
        dropped = (busy_left > 0) || i_init;
        e_rv = i_rd && !dropped;
        if (e_rv) begin
            e_hit = (rk < DEPTH) && m_ok[rk];
            e_rd  = e_hit ? m_val[rk] : DEFV;
        end
        e_werr = i_wr && (dropped || wk >= DEPTH);
        if (i_wr && !dropped && wk < DEPTH) begin
            m_val[wk] = wd;
            m_ok[wk]  = 1'b1;
        end
        if (i_init) begin
            busy_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_ok[i] = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 8'h00, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; init = 0; wr_en = 0; wr_key = 0; wr_data = 0; rd_en = 0; rd_key = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #3 rst_n = 1'b1;

        // sweep after reset: busy for exactly DEPTH edges
        idle("sweep", DEPTH + 2);

        step("wr5", 0, 1, 5, 8'h5B, 0, 0);
        step("rd5", 0, 0, 0, 8'h00, 1, 5);
        step("rewr5", 0, 1, 5, 8'h6D, 0, 0);
        step("rd5b", 0, 0, 0, 8'h00, 1, 5);
        step("rd7", 0, 0, 0, 8'h00, 1, 7);
        step("wr40", 0, 1, 40, 8'hAA, 0, 0);
        step("rd40", 0, 0, 0, 8'h00, 1, 40);
        step("hold", 0, 0, 0, 8'h00, 0, 0);

        step("wr3", 0, 1, 3, 8'h23, 0, 0);
        step("rw3", 0, 1, 3, 8'h8E, 1, 3);
        step("rd3", 0, 0, 0, 8'h00, 1, 3);

        // init restart: fill, clear, write during busy, then all miss
        for (int k = 0; k < DEPTH; k++) step("fill", 0, 1, k, 8'($urandom), 0, 0);
        step("init", 1, 0, 0, 8'h00, 0, 0);
        step("wrbusy", 0, 1, 9, 8'h99, 0, 0);
        step("rdbusy", 0, 0, 0, 8'h00, 1, 9);
        idle("isweep", DEPTH);
        for (int k = 0; k < 40; k++) step("miss", 0, 0, 0, 8'h00, 1, k);

        // restart sweep mid-sweep
        step("init2", 1, 0, 0, 8'h00, 0, 0);
        idle("mid", 10);
        step("init3", 1, 1, 4, 8'h44, 1, 4);
        idle("restart", DEPTH + 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step("rand", ($urandom_range(0, 127) == 0),
                 $urandom_range(0, 1), $urandom_range(0, 47), 8'($urandom),
                 $urandom_range(0, 1), $urandom_range(0, 47));
        end
        idle("drain", DEPTH + 1);

        // async reset during a read burst
        for (int k = 0; k < 6; k++) step("burst", 0, 1, k, 8'(k + 8'h30), 1, k);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst.busy",   32'(busy),     32'd1);
        check_val("arst.rd_vld", 32'(rd_valid), 32'd0);
        check_val("arst.rd_dat", 32'(rd_data),  32'(DEFV));
        check_val("arst.rd_hit", 32'(rd_hit),   32'd0);
        check_val("arst.wr_err", 32'(wr_err),   32'd0);
        check_val("arst.count",  32'(count),    32'd0);
        model_reset();
        #5 rst_n = 1'b1;
        for (int k = 0; k < DEPTH + 2; k++) step("post", 0, 0, 0, 8'h00, 1, k % DEPTH);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_lut.md
# prog_lut

Programmable, parametrised lookup table that replaces the fixed constant/branch-target LUT. Software or the loader writes key->value entries at run time, and the fetch/branch unit reads them back one cycle after the request. Each entry has a valid bit, so unwritten or out-of-range keys report a miss instead of silently returning 0. A clear sequencer sweeps the table after reset or on request.

## Interface
- KEY_W, 8, key width in bits
- DATA_W, 8, entry width in bits
- DEPTH, 32, number of entries (1..2^KEY_W); keys >= DEPTH are out of range
- DEFAULT_VAL, 0, value returned on a miss and written by the clear sweep

Ports (clock and reset first):
- clk  in  1  single clock, all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- init  in  1  pulse: start (or restart) a clear sweep
- busy  out  1  high while the clear sweep runs
- wr_en  in  1  write strobe
- wr_key  in  KEY_W  write key
- wr_data  in  DATA_W  write value
- wr_err  out  1  one-cycle pulse: the write was rejected
- rd_en  in  1  read request
- rd_key  in  KEY_W  read key
- rd_valid  out  1  one-cycle pulse: the read result is present
- rd_data  out  DATA_W  read result; holds its value between reads
- rd_hit  out  1  1 = key in range and entry valid; holds its value between reads
- count  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- States: CLEAR and IDLE.
- Reset (asynchronous) sets:
  - state = CLEAR, sweep pointer = 0, all valid bits = 0, count = 0
  - busy = 1, rd_valid = 0, rd_data = DEFAULT_VAL, rd_hit = 0, wr_err = 0
- CLEAR:
  - Each edge writes DEFAULT_VAL to entry[ptr], clears valid[ptr] and increments ptr.
  - On the edge that clears DEPTH-1, the state moves to IDLE and ptr returns to 0.
- IDLE, init = 1: state -> CLEAR, ptr = 0, count = 0 and all valid bits = 0 on the same edge.
- CLEAR, init = 1: ptr restarts at 0; the sweep length restarts.
- During CLEAR, wr_en and rd_en are dropped.
  - A dropped write pulses wr_err.
  - A dropped read produces no rd_valid.
- Write in IDLE:
  - wr_key < DEPTH: entry = wr_data and valid = 1. count increments only if the entry was previously invalid.
  - wr_key >= DEPTH: no state change, wr_err pulses.
- Read in IDLE: the result is registered.
  - Hit: rd_data = entry and rd_hit = 1.
  - Miss (invalid entry or key >= DEPTH): rd_data = DEFAULT_VAL and rd_hit = 0.
- Read and write to the same key in the same cycle: the read returns the pre-write contents (read-before-write).
- count never exceeds DEPTH and never wraps.

## Timing
- Read latency is 1 cycle: rd_en sampled at edge N -> rd_valid/rd_data/rd_hit are valid after edge N, for one cycle.
- Back-to-back reads are allowed at one per cycle, with no bubbles.
- A write at edge N is visible to a read sampled at edge N+1.
- After rst_n rises, the sweep takes exactly DEPTH edges; busy falls after the DEPTH-th edge.
- init asserted at edge N makes busy = 1 after edge N.
  - busy falls after edge N+DEPTH.
  - A read or write presented on edge N is dropped.
- wr_err and rd_valid are registered, asserted the cycle after the offending or requesting edge.
- rst_n asserted mid-sweep or mid-read returns everything to the reset values immediately, without waiting for clk.

## Test plan
- **Reset/sweep:** release rst_n with DEPTH = 32 -> busy = 1 for 32 cycles then 0; count = 0; rd_data = 0 and rd_valid = 0 throughout.
- **Write/read hit:** write key 5 = 0x5B, read key 5 next cycle -> one cycle later rd_valid = 1, rd_hit = 1, rd_data = 0x5B; count = 1. A rewrite of key 5 = 0x6D leaves count = 1.
- **Misses:** read key 7 (never written) -> rd_hit = 0, rd_data = DEFAULT_VAL. Write key 40 (>= DEPTH) -> wr_err pulses one cycle, count is unchanged; a read of key 40 misses.
- **Same-cycle read/write:** key 3 = 0x23, then write key 3 = 0x8E while reading key 3 -> the read returns 0x23; the following read returns 0x8E.
- **init:** fill keys 0..31 so count = 32, then pulse init -> count = 0 on the next cycle and busy for 32 cycles. A write issued during busy gets wr_err = 1. After busy falls, every key misses.
- **Async reset mid-operation:** rst_n low for half a cycle during a read burst -> outputs go to reset values immediately, with no rd_valid pulse; the sweep restarts from 0 after release.
